// File: rtl/squash_ctrl.sv
// squash_ctrl: holds the oldest pending branch/violation redirect and fires a single squash pulse
// once the ROB head reaches it. The optional load-violation path is guarded by SQUASH_VIOLATION_EN.

package squash_pkg;
  localparam int XLEN                = 64;
  localparam int MEMDEP_FOLDPC_WIDTH = 10;
  localparam int ROB_SIZE            = 64;
  localparam int ROB_IDX_W           = $clog2(ROB_SIZE);

  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t           rob_idx;
    logic              has_mispred;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    logic                           dueToBranch;
    logic                           dueToViolation;
    logic                           branch_taken;
    logic [XLEN-1:0]                arch_pc;
    logic [MEMDEP_FOLDPC_WIDTH-1:0] store_foldpc;
    logic [MEMDEP_FOLDPC_WIDTH-1:0] load_foldpc;
  } squashInfo_t;

  typedef enum logic {KIND_BRANCH, KIND_VIOLATION} kind_t;

  // The flag bit flips on every ROB wrap, so differing flags invert the index order.
  function automatic logic older(robIdx_t a, robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction
endpackage

module squash_ctrl
  import squash_pkg::*;
#(
  parameter int NUM_BRU  = 2,
  parameter int ROB_SIZE = squash_pkg::ROB_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_flush,
  input  logic [NUM_BRU-1:0]                    i_bru_vld,
  input  branchwbInfo_t [NUM_BRU-1:0]           i_bru_info,
  input  logic                                  i_vio_vld,
  input  robIdx_t                               i_vio_rob_idx,
  input  logic [XLEN-1:0]                       i_vio_pc,
  input  logic [MEMDEP_FOLDPC_WIDTH-1:0]        i_vio_store_foldpc,
  input  logic [MEMDEP_FOLDPC_WIDTH-1:0]        i_vio_load_foldpc,
  input  robIdx_t                               i_rob_head_idx,
  input  logic                                  i_head_retire,
  output logic                                  o_pend_vld,
  output robIdx_t                               o_pend_rob_idx,
  output logic                                  o_squash_vld,
  output squashInfo_t                           o_squash_info
);

  // robIdx_t is sized by the package, so the parameter must agree with it.
  if (ROB_SIZE != squash_pkg::ROB_SIZE) begin : g_rob_size_check
    $error("squash_ctrl: ROB_SIZE must match squash_pkg::ROB_SIZE");
  end

  typedef enum logic [1:0] {IDLE, PEND, FIRE} state_t;

  typedef struct packed {
    kind_t                          kind;
    robIdx_t                        rob_idx;
    logic                           taken;
    logic [XLEN-1:0]                pc;
    logic [MEMDEP_FOLDPC_WIDTH-1:0] store_foldpc;
    logic [MEMDEP_FOLDPC_WIDTH-1:0] load_foldpc;
  } record_t;

  state_t  state;
  record_t rec;
  record_t cand;
  logic    cand_vld;
  logic    fire_cond;

  // Oldest-candidate select; strict older() lets the lower port keep an equal rob_idx.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    cand_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_BRU; i++) begin
      if (i_bru_vld[i] && i_bru_info[i].has_mispred &&
          (!cand_vld || older(i_bru_info[i].rob_idx, cand.rob_idx))) begin
        cand_vld          = 1'b1;
        cand.kind         = KIND_BRANCH;
        cand.rob_idx      = i_bru_info[i].rob_idx;
        cand.taken        = i_bru_info[i].branch_taken;
        cand.pc           = i_bru_info[i].branch_npc;
        cand.store_foldpc = '0;
        cand.load_foldpc  = '0;
      end
    end
`ifdef SQUASH_VIOLATION_EN
    if (i_vio_vld && (!cand_vld || older(i_vio_rob_idx, cand.rob_idx))) begin
      cand_vld          = 1'b1;
      cand.kind         = KIND_VIOLATION;
      cand.rob_idx      = i_vio_rob_idx;
      cand.taken        = 1'b0;
      cand.pc           = i_vio_pc;
      cand.store_foldpc = i_vio_store_foldpc;
      cand.load_foldpc  = i_vio_load_foldpc;
    end
`endif
  end

`ifndef SQUASH_VIOLATION_EN
  logic unused_vio;
  assign unused_vio = ^{i_vio_vld, i_vio_rob_idx, i_vio_pc, i_vio_store_foldpc, i_vio_load_foldpc};
`endif

  // A violating load is refetched rather than retired, so it fires without i_head_retire.
  assign fire_cond = (state == PEND) && (i_rob_head_idx == rec.rob_idx) &&
                     ((rec.kind == KIND_VIOLATION) || i_head_retire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rec           <= '0;
      o_squash_vld  <= 1'b0;
      o_squash_info <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      o_squash_vld  <= 1'b0;
      o_squash_info <= '0;
      if (i_flush) begin
        state <= IDLE;
        rec   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cand_vld) begin
              rec   <= cand;
              state <= PEND;
            end
          end
          PEND: begin
            if (fire_cond) begin
              state                      <= FIRE;
              o_squash_vld               <= 1'b1;
              o_squash_info.dueToBranch  <= (rec.kind == KIND_BRANCH);
              o_squash_info.branch_taken <= rec.taken;
              o_squash_info.arch_pc      <= rec.pc;
`ifdef SQUASH_VIOLATION_EN
              o_squash_info.dueToViolation <= (rec.kind == KIND_VIOLATION);
              o_squash_info.store_foldpc   <= rec.store_foldpc;
              o_squash_info.load_foldpc    <= rec.load_foldpc;
`endif
            end else if (cand_vld && older(cand.rob_idx, rec.rob_idx)) begin
              rec <= cand;
            end
          end
          FIRE: begin
            // Anything arriving now is younger than the squash and is dropped.
            state <= IDLE;
            rec   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_pend_vld     = (state == PEND);
  assign o_pend_rob_idx = rec.rob_idx;

endmodule
